// File: rtl/ttl_mux_pkg.sv
// rtl/ttl_mux_pkg.sv - shared states, requester indices and widths for ttl_mux_scheduler
package ttl_mux_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2
  } state_t;

  localparam int unsigned REQ_Z   = 0;
  localparam int unsigned REQ_REG = 1;
  localparam int unsigned REQ_A   = 2;
  localparam int unsigned REQ_B   = 3;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned HOLD_W = 4;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin pick starting after ptr
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] win
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    win   = 4'b0000;
    found = 1'b0;
    idx   = 2'd0;
    // Offsets 1..4 wrap naturally in two bits, so ptr itself is checked last.
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttl_mux_scheduler.sv
// rtl/ttl_mux_scheduler.sv - round-robin output-mux scheduler with bounded tenure
// Optional per-requester grant counters on gcnt when GRANT_CNT_EN is defined.
module ttl_mux_scheduler
  import ttl_mux_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       sub2,
  input  logic [1:0] sub3,
  output logic [3:0] gnt,
  output logic [3:0] sel,
  output logic       sel2,
  output logic [1:0] sel3,
  output logic       ld,
  output logic       clr,
  output logic       busy
`ifdef GRANT_CNT_EN
  ,
  output logic [4*CNT_W-1:0] gcnt
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_M1 = HOLD_W'(HOLD - 1);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [3:0]        sel_q, sel_d;
  logic              sel2_q, sel2_d;
  logic [1:0]        sel3_q, sel3_d;
  logic              ld_q, ld_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic [3:0]        win;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 4'b0000;
      sel2_q  <= 1'b0;
      sel3_q  <= 2'b00;
      ld_q    <= 1'b0;
      clr_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      sel2_q  <= sel2_d;
      sel3_q  <= sel3_d;
      ld_q    <= ld_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    sel2_d  = sel2_q;
    sel3_d  = sel3_q;
    ld_d    = ld_q;
    clr_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      INIT: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        sel_d   = 4'b0000;
        ld_d    = 1'b0;
        busy_d  = 1'b0;
      end
      IDLE: begin
        gnt_d  = 4'b0000;
        sel_d  = 4'b0000;
        ld_d   = 1'b0;
        busy_d = 1'b0;
        if (req != 4'b0000) begin
          state_d = BUSY;
          gnt_d   = win;
          sel_d   = win;
          ld_d    = win[REQ_REG];
          busy_d  = 1'b1;
          cnt_d   = HOLD_M1;
          ptr_d   = onehot_to_idx(win);
          if (win[REQ_A]) sel2_d = sub2;
          if (win[REQ_B]) sel3_d = sub3;
        end
      end
      BUSY: begin
        // Only the owner's bit matters here; other requesters wait for IDLE.
        if (cnt_q == '0 || (req & gnt_q) == 4'b0000) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          sel_d   = 4'b0000;
          ld_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        clr_d   = 1'b1;
        gnt_d   = 4'b0000;
        sel_d   = 4'b0000;
        ld_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign sel2 = sel2_q;
  assign sel3 = sel3_q;
  assign ld   = ld_q;
  assign clr  = clr_q;
  assign busy = busy_q;

`ifdef GRANT_CNT_EN
  logic [CNT_W-1:0] gcnt_q [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) gcnt_q[i] <= '0;
    end else if (state_q == IDLE && req != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (win[i] && gcnt_q[i] != {CNT_W{1'b1}}) gcnt_q[i] <= gcnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    gcnt = '0;
    for (int i = 0; i < 4; i++) gcnt[i*CNT_W +: CNT_W] = gcnt_q[i];
  end
`endif

endmodule

// File: doc/ttl_mux_scheduler.md
TTL_MUX_SCHEDULER -- requirements
Module: ttl_mux_scheduler

Interface
REQ-001 Parameter: HOLD, default 4, maximum grant tenure in cycles; legal range 1..16.
REQ-002 Port: clk  input  1  the single clock; every state element updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: req  input  4  request bits; req[0] selects the direct z path, req[1] the loaded register, req[2] the a-pair, req[3] the b-quad.
REQ-005 Port: sub2  input  1  a-pair index, captured when req[2] is granted.
REQ-006 Port: sub3  input  2  b-quad index, captured when req[3] is granted.
REQ-007 Port: gnt  output  4  one-hot grant, or all zero.
REQ-008 Port: sel  output  4  one-hot output-mux select; equals gnt when busy and 4'b0000 when idle.
REQ-009 Port: sel2  output  1  registered a-pair select.
REQ-010 Port: sel3  output  2  registered b-quad select.
REQ-011 Port: ld  output  1  register load-enable.
REQ-012 Port: clr  output  1  register clear.
REQ-013 Port: busy  output  1  high while a grant is active.

Function
REQ-014 The block SHALL implement three states, INIT, IDLE and BUSY; every output SHALL be a registered signal.
REQ-015 INIT SHALL hold clr=1 and all other outputs 0 for exactly one cycle, then go to IDLE.
REQ-016 In IDLE with req!=0, the block SHALL pick a winner round-robin, starting from the bit after the last grantee; after reset that pointer SHALL be 3, so bit 0 wins first.
REQ-017 On the transition from IDLE to BUSY, gnt, sel and busy SHALL assert on the next edge, and the hold counter SHALL load HOLD-1; latency from req to gnt is exactly 1 cycle.
REQ-018 sel2 SHALL capture sub2, and sel3 SHALL capture sub3, only on the edge that grants req[2] or req[3] respectively; at all other times both SHALL keep their value.
REQ-019 ld SHALL equal 1 only while gnt[1]=1.
REQ-020 In BUSY the counter SHALL decrement each cycle; BUSY SHALL exit to IDLE when the counter reaches 0 or the owner's req bit is 0.
REQ-021 On the exit edge from BUSY, gnt, sel, ld and busy SHALL all return to 0.
REQ-022 There SHALL be no back-to-back grant: at least one IDLE cycle separates any two tenures, including when the same requester re-requests.
REQ-023 Changes on non-owner req bits during BUSY SHALL be ignored; only the IDLE-cycle sample counts.
REQ-024 With HOLD=1, each tenure SHALL last exactly 1 cycle.
REQ-025 The round-robin pointer SHALL wrap from 3 to 0.

Reset
REQ-026 While reset=1, the block SHALL hold gnt=0, sel=0, sel2=0, sel3=0, ld=0, busy=0, clr=1, pointer=3 and state=INIT.
REQ-027 A reset asserted mid-BUSY SHALL drop the grant on that same edge; no partial tenure resumes after reset.

Configuration
REQ-028 With macro GRANT_CNT_EN defined, the block SHALL add output gcnt (4x8 bits, packed as 32 bits), with one saturating counter per requester incremented on each grant edge and cleared by reset.
REQ-029 Without GRANT_CNT_EN, the gcnt port and its counters SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-030 A shared package ttl_mux_pkg SHALL hold the state enum (INIT/IDLE/BUSY), the requester index constants (REQ_Z=0, REQ_REG=1, REQ_A=2, REQ_B=3) and the counter width constant.
REQ-031 A single sub-module rr_pick4 (combinational: req, pointer -> one-hot winner) SHALL be instantiated once.

Verification
REQ-032 Release reset with req=0 -> clr=1 for one cycle, then all outputs 0 and busy=0.
REQ-033 req=4'b1111 held, HOLD=4 -> grant order 0,1,2,3,0, each tenure 4 cycles, one IDLE cycle between tenures.
REQ-034 req[3]=1 with sub3=2'b10 -> sel=4'b1000 and sel3=2'b10; change sub3 mid-tenure -> sel3 unchanged.
REQ-035 req[1]=1 dropped on the 2nd BUSY cycle -> ld=1 for 2 cycles, busy low on the next edge.
REQ-036 reset pulsed on the 3rd BUSY cycle -> gnt=0 and clr=1 on that edge; the next grant goes to req[0] if it is set.
REQ-037 With GRANT_CNT_EN and 300 grants to req[2] -> gcnt[23:16] saturates at 255.
